// File: rtl/p09_sync_debounce.sv
// rtl/p09_sync_debounce.sv - multi-channel input synchronizer with debounce filter and edge strobes
//
// Purpose:
//   Conditions WIDTH asynchronous pad-level inputs for core logic. Each channel
//   passes through an FF_COUNT-deep synchronizer, then a debounce filter that
//   only accepts a new level after DEBOUNCE_CYCLES consecutive cycles of
//   disagreement with the current level. Accepted transitions produce one-cycle
//   rise/fall strobes that coincide with the first cycle level_o shows the new
//   value.
//
// Ports:
//   clk        in   1      single clock, all state on rising edge
//   reset_n    in   1      synchronous active-low reset (not synchronized here)
//   in         in   WIDTH  asynchronous raw inputs
//   level_o    out  WIDTH  debounced, synchronized level
//   rise_o     out  WIDTH  one-cycle pulse on accepted 0->1 of level_o
//   fall_o     out  WIDTH  one-cycle pulse on accepted 1->0 of level_o
//   changed_o  out  1      registered OR of all rise/fall strobes
module p09_sync_debounce #(
   parameter int               WIDTH           = 4,
   parameter int               FF_COUNT        = 3,
   parameter int               DEBOUNCE_CYCLES = 16,
   parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] in,
   output logic [WIDTH-1:0] level_o,
   output logic [WIDTH-1:0] rise_o,
   output logic [WIDTH-1:0] fall_o,
   output logic             changed_o
);

   // Counter must be able to hold DEBOUNCE_CYCLES-1; sized with one spare code
   // so DEBOUNCE_CYCLES=1 still yields a legal 1-bit counter.
   localparam int             CW       = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

   // Synchronizer: stage k holds all channels' bit at depth k.
   logic [FF_COUNT-1:0][WIDTH-1:0] pipe_q;
   logic [FF_COUNT-1:0][WIDTH-1:0] pipe_d;
   logic [WIDTH-1:0]               sync_s;

   // Debounce state.
   logic [WIDTH-1:0][CW-1:0]       cnt_q;
   logic [WIDTH-1:0][CW-1:0]       cnt_d;
   logic [WIDTH-1:0]               level_q;
   logic [WIDTH-1:0]               level_d;
   logic [WIDTH-1:0]               rise_q;
   logic [WIDTH-1:0]               rise_d;
   logic [WIDTH-1:0]               fall_q;
   logic [WIDTH-1:0]               fall_d;
   logic                           changed_q;
   logic                           changed_d;

   // Plain shift register, no logic between stages.
   always_comb begin
      pipe_d = {pipe_q[FF_COUNT-2:0], in};
   end

   assign sync_s = pipe_q[FF_COUNT-1];

   // Per-channel filter. Any agreement between the synchronized input and the
   // current level clears the count, so partial counts never carry over. The
   // count saturates by construction: reaching CNT_LAST with continued
   // disagreement accepts the level and restarts at zero.
   always_comb begin
      cnt_d   = cnt_q;
      level_d = level_q;
      rise_d  = '0;
      fall_d  = '0;
      for (int ch = 0; ch < WIDTH; ch++) begin
         if (sync_s[ch] == level_q[ch]) begin
            cnt_d[ch] = '0;
         end else if (cnt_q[ch] == CNT_LAST) begin
            level_d[ch] = sync_s[ch];
            cnt_d[ch]   = '0;
            rise_d[ch]  = sync_s[ch];
            fall_d[ch]  = ~sync_s[ch];
         end else begin
            cnt_d[ch] = cnt_q[ch] + CNT_ONE;
         end
      end
      changed_d = |(rise_d | fall_d);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         pipe_q    <= {FF_COUNT{RESET_VALUE}};
         cnt_q     <= '0;
         level_q   <= RESET_VALUE;
         rise_q    <= '0;
         fall_q    <= '0;
         changed_q <= 1'b0;
      end else begin
         pipe_q    <= pipe_d;
         cnt_q     <= cnt_d;
         level_q   <= level_d;
         rise_q    <= rise_d;
         fall_q    <= fall_d;
         changed_q <= changed_d;
      end
   end

   assign level_o   = level_q;
   assign rise_o    = rise_q;
   assign fall_o    = fall_q;
   assign changed_o = changed_q;

endmodule

// File: tb/tb_p09_sync_debounce.sv
// tb/tb_p09_sync_debounce.sv - directed self-checking bench for p09_sync_debounce
module tb_p09_sync_debounce;

   logic       clk;
   logic       reset_n;
   logic [3:0] in_a;
   logic [3:0] lvl_a;
   logic [3:0] rise_a;
   logic [3:0] fall_a;
   logic       chg_a;
   logic [3:0] in_b;
   logic [3:0] lvl_b;
   logic [3:0] rise_b;
   logic [3:0] fall_b;
   logic       chg_b;

   int n_checks;
   int n_fail;

   p09_sync_debounce #(
      .WIDTH(4), .FF_COUNT(3), .DEBOUNCE_CYCLES(4), .RESET_VALUE(4'b0000)
   ) dut_a (
      .clk(clk), .reset_n(reset_n), .in(in_a),
      .level_o(lvl_a), .rise_o(rise_a), .fall_o(fall_a), .changed_o(chg_a)
   );

   p09_sync_debounce #(
      .WIDTH(4), .FF_COUNT(3), .DEBOUNCE_CYCLES(4), .RESET_VALUE(4'b1010)
   ) dut_b (
      .clk(clk), .reset_n(reset_n), .in(in_b),
      .level_o(lvl_b), .rise_o(rise_b), .fall_o(fall_b), .changed_o(chg_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance n rising edges; return 1 time unit after the last one.
   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Observed/expected packed as {level[3:0], rise[3:0], fall[3:0], changed}.
   task automatic chk(input string tag, input logic [12:0] obs, input logic [12:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      reset_n  = 1'b0;
      in_a     = 4'b0000;
      in_b     = 4'b1010;
      tick(3);
      reset_n  = 1'b1;

      // Reset state of both instances.
      chk("reset_a", {lvl_a, rise_a, fall_a, chg_a}, {4'b0000, 4'b0000, 4'b0000, 1'b0});
      chk("reset_b", {lvl_b, rise_b, fall_b, chg_b}, {4'b1010, 4'b0000, 4'b0000, 1'b0});

      // 1: idle 20 cycles, nothing moves; B holds its reset value with no strobes.
      for (int i = 0; i < 20; i++) begin
         tick(1);
         chk("t1_idle_a", {lvl_a, rise_a, fall_a, chg_a}, {4'b0000, 4'b0000, 4'b0000, 1'b0});
         chk("t1_idle_b", {lvl_b, rise_b, fall_b, chg_b}, {4'b1010, 4'b0000, 4'b0000, 1'b0});
      end

      // 2: in[0] rises; accepted at the 7th edge (E+6).
      in_a = 4'b0001;
      tick(6);
      chk("t2_pre",  {lvl_a, rise_a, fall_a, chg_a}, {4'b0000, 4'b0000, 4'b0000, 1'b0});
      tick(1);
      chk("t2_rise", {lvl_a, rise_a, fall_a, chg_a}, {4'b0001, 4'b0001, 4'b0000, 1'b1});
      tick(1);
      chk("t2_hold", {lvl_a, rise_a, fall_a, chg_a}, {4'b0001, 4'b0000, 4'b0000, 1'b0});

      // 3a: in[1] high for 3 cycles is rejected.
      in_a = 4'b0011;
      tick(3);
      in_a = 4'b0001;
      for (int i = 0; i < 10; i++) begin
         tick(1);
         chk("t3_short", {lvl_a, rise_a, fall_a, chg_a}, {4'b0001, 4'b0000, 4'b0000, 1'b0});
      end

      // 3b: in[1] high for 4 cycles is accepted, then falls 4 cycles later.
      in_a = 4'b0011;
      tick(4);
      in_a = 4'b0001;
      tick(2);
      chk("t3_pre",   {lvl_a, rise_a, fall_a, chg_a}, {4'b0001, 4'b0000, 4'b0000, 1'b0});
      tick(1);
      chk("t3_rise",  {lvl_a, rise_a, fall_a, chg_a}, {4'b0011, 4'b0010, 4'b0000, 1'b1});
      tick(3);
      chk("t3_held",  {lvl_a, rise_a, fall_a, chg_a}, {4'b0011, 4'b0000, 4'b0000, 1'b0});
      tick(1);
      chk("t3_fall",  {lvl_a, rise_a, fall_a, chg_a}, {4'b0001, 4'b0000, 4'b0010, 1'b1});
      tick(1);
      chk("t3_quiet", {lvl_a, rise_a, fall_a, chg_a}, {4'b0001, 4'b0000, 4'b0000, 1'b0});

      // Return channel 0 low before the all-channel test.
      in_a = 4'b0000;
      tick(7);
      chk("t4_clr",   {lvl_a, rise_a, fall_a, chg_a}, {4'b0000, 4'b0000, 4'b0001, 1'b1});
      tick(1);

      // 4: all four channels rise together, then only channel 2 falls.
      in_a = 4'b1111;
      tick(6);
      chk("t4_pre",   {lvl_a, rise_a, fall_a, chg_a}, {4'b0000, 4'b0000, 4'b0000, 1'b0});
      tick(1);
      chk("t4_rise",  {lvl_a, rise_a, fall_a, chg_a}, {4'b1111, 4'b1111, 4'b0000, 1'b1});
      tick(1);
      chk("t4_hold",  {lvl_a, rise_a, fall_a, chg_a}, {4'b1111, 4'b0000, 4'b0000, 1'b0});
      in_a = 4'b1011;
      tick(6);
      chk("t4_pre2",  {lvl_a, rise_a, fall_a, chg_a}, {4'b1111, 4'b0000, 4'b0000, 1'b0});
      tick(1);
      chk("t4_fall2", {lvl_a, rise_a, fall_a, chg_a}, {4'b1011, 4'b0000, 4'b0100, 1'b1});
      tick(1);
      chk("t4_quiet", {lvl_a, rise_a, fall_a, chg_a}, {4'b1011, 4'b0000, 4'b0000, 1'b0});

      // Return remaining channels low.
      in_a = 4'b0000;
      tick(7);
      chk("t5_clr",   {lvl_a, rise_a, fall_a, chg_a}, {4'b0000, 4'b0000, 4'b1011, 1'b1});
      tick(1);

      // 5: in[3] rises at edge E, reset at E+4 discards the partial count.
      in_a = 4'b1000;
      tick(4);
      reset_n = 1'b0;
      tick(1);
      reset_n = 1'b1;
      chk("t5_rst",   {lvl_a, rise_a, fall_a, chg_a}, {4'b0000, 4'b0000, 4'b0000, 1'b0});
      chk("t6_rst_b", {lvl_b, rise_b, fall_b, chg_b}, {4'b1010, 4'b0000, 4'b0000, 1'b0});
      for (int i = 0; i < 6; i++) begin
         tick(1);
         chk("t5_wait", {lvl_a, rise_a, fall_a, chg_a}, {4'b0000, 4'b0000, 4'b0000, 1'b0});
      end
      tick(1);
      chk("t5_rise",  {lvl_a, rise_a, fall_a, chg_a}, {4'b1000, 4'b1000, 4'b0000, 1'b1});
      tick(1);
      chk("t5_hold",  {lvl_a, rise_a, fall_a, chg_a}, {4'b1000, 4'b0000, 4'b0000, 1'b0});

      // 6: B never strobes while its input matches its reset value.
      for (int i = 0; i < 5; i++) begin
         tick(1);
         chk("t6_b", {lvl_b, rise_b, fall_b, chg_b}, {4'b1010, 4'b0000, 4'b0000, 1'b0});
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
